// File: rtl/sar_pkg.sv
// sar_pkg -- shared types and constants for the SAR scan controller.
// Optional averaging build: define SAR_SCAN_AVG_EN.
package sar_pkg;

    localparam int SAR_WIDTH      = 8;
    localparam int AVG_SAMPLES    = 4;
    localparam int SUM_WIDTH      = 10;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_SETTLE_CYC = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_CONVERT,
        ST_OUTPUT
    } sar_state_e;

endpackage

// File: rtl/sar_ch_picker.sv
// sar_ch_picker -- finds the lowest set mask bit above an index
// (or at/above it when incl_i is set), plus a none-left flag.
module sar_ch_picker #(
    parameter  int NUM_CH = 4,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CHW-1:0]    idx_i,
    input  logic              incl_i,
    output logic [CHW-1:0]    next_o,
    output logic              none_o
);

    // Scan downward so the last hit wins, leaving the lowest candidate.
    always_comb begin
        next_o = '0;
        none_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] &&
                ((i > int'(idx_i)) || (incl_i && (i == int'(idx_i))))) begin
                next_o = CHW'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl -- round-robin SAR scan over the enabled mux channels.
// Define SAR_SCAN_AVG_EN for 4-sample averaging per channel.
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int CHW        = $clog2(NUM_CH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [NUM_CH-1:0]    ch_mask_i,
    output logic [CHW-1:0]       mux_sel_o,
    output logic                 conv_start_o,
    input  logic                 conv_rdy_i,
    input  logic [SAR_WIDTH-1:0] conv_data_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [CHW-1:0]       res_ch_o,
    output logic [SAR_WIDTH-1:0] res_data_o,
    output logic                 busy_o,
    output logic                 sweep_done_o
);

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

    sar_state_e           r_state;
    logic [NUM_CH-1:0]    r_mask;
    logic [CHW-1:0]       r_ch;
    logic [7:0]           r_cnt;
    logic                 r_start;
    logic                 r_valid;
    logic                 r_done;
    logic [SAR_WIDTH-1:0] r_data;

    logic [CHW-1:0]       w_next_ch;
    logic                 w_none_left;
    logic [CHW-1:0]       w_first_ch;
    logic                 w_none_set;
    logic                 w_last;
    logic [SAR_WIDTH-1:0] w_result;

    // Next channel of the latched sweep mask.
    sar_ch_picker #(.NUM_CH(NUM_CH)) u_next (
        .mask_i (r_mask),
        .idx_i  (r_ch),
        .incl_i (1'b0),
        .next_o (w_next_ch),
        .none_o (w_none_left)
    );

    // First channel of a new sweep, taken from the live mask.
    sar_ch_picker #(.NUM_CH(NUM_CH)) u_first (
        .mask_i (ch_mask_i),
        .idx_i  ('0),
        .incl_i (1'b1),
        .next_o (w_first_ch),
        .none_o (w_none_set)
    );

`ifdef SAR_SCAN_AVG_EN
    logic [SUM_WIDTH-1:0] r_sum;
    logic [1:0]           r_nsamp;
    logic [SUM_WIDTH-1:0] w_sum;

    assign w_sum    = r_sum + SUM_WIDTH'(conv_data_i);
    assign w_last   = (r_nsamp == 2'(AVG_SAMPLES - 1));
    assign w_result = w_sum[SUM_WIDTH-1:2];
`else
    assign w_last   = 1'b1;
    assign w_result = conv_data_i;
`endif

    // Scan sequencer: settle, start, convert, hand off, pick next channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
`ifdef SAR_SCAN_AVG_EN
            r_sum   <= '0;
            r_nsamp <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (en_i && !w_none_set) begin
                        r_mask  <= ch_mask_i;
                        r_ch    <= w_first_ch;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_START: begin
                    r_state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (conv_rdy_i) begin
`ifdef SAR_SCAN_AVG_EN
                        r_sum   <= w_last ? '0 : w_sum;
                        r_nsamp <= w_last ? '0 : r_nsamp + 2'd1;
`endif
                        if (w_last) begin
                            r_data  <= w_result;
                            r_valid <= 1'b1;
                            r_state <= ST_OUTPUT;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_START;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_none_left) begin
                            r_done <= 1'b1;
                            if (en_i && !w_none_set) begin
                                r_mask  <= ch_mask_i;
                                r_ch    <= w_first_ch;
                                r_state <= ST_SETTLE;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else if (en_i) begin
                            r_ch    <= w_next_ch;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mux_sel_o    = r_ch;
    assign res_ch_o     = r_ch;
    assign conv_start_o = r_start;
    assign res_valid_o  = r_valid;
    assign res_data_o   = r_data;
    assign busy_o       = (r_state != ST_IDLE);
    assign sweep_done_o = r_done;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl -- randomized bench with a sweep-list reference model
// and a SAR core stand-in; directed cases pin key timings.
`timescale 1ns/1ps
module tb_sar_scan_ctrl;

    localparam int NUM_CH     = 4;
    localparam int SETTLE_CYC = 8;
    localparam int CHW        = $clog2(NUM_CH);
`ifdef SAR_SCAN_AVG_EN
    localparam int NSAMP = 4;
`else
    localparam int NSAMP = 1;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              en_i = 1'b0;
    logic [NUM_CH-1:0] ch_mask_i = '0;
    logic              conv_rdy_i = 1'b0;
    logic [7:0]        conv_data_i = '0;
    logic              res_ready_i = 1'b0;
    logic [CHW-1:0]    mux_sel_o;
    logic [CHW-1:0]    res_ch_o;
    logic              conv_start_o;
    logic              res_valid_o;
    logic [7:0]        res_data_o;
    logic              busy_o;
    logic              sweep_done_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    sar_scan_ctrl #(.NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .ch_mask_i    (ch_mask_i),
        .mux_sel_o    (mux_sel_o),
        .conv_start_o (conv_start_o),
        .conv_rdy_i   (conv_rdy_i),
        .conv_data_i  (conv_data_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_ch_o     (res_ch_o),
        .res_data_o   (res_data_o),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: a sweep is the list of set mask bits; the
    // current channel is the list head.
    bit   m_busy, m_start, m_conv, m_valid, m_done;
    int   m_settle, m_ch, m_data;
    int   m_list[$];
    int   m_samp[$];
    int   core_wait;
    logic [7:0] core_q[$];

    task automatic model_reset();
        m_busy = 0; m_start = 0; m_conv = 0; m_valid = 0; m_done = 0;
        m_settle = 0; m_ch = 0; m_data = 0;
        m_list.delete();
        m_samp.delete();
    endtask

    task automatic begin_sweep(input logic [NUM_CH-1:0] mask);
        m_list.delete();
        for (int i = 0; i < NUM_CH; i++)
            if (mask[i]) m_list.push_back(i);
        m_ch = m_list[0];
        m_settle = SETTLE_CYC;
        m_samp.delete();
    endtask

    task automatic model_step();
        bit nstart;
        bit ndone;
        int s;
        nstart = 0;
        ndone  = 0;
        if (!m_busy) begin
            if (en_i && ch_mask_i != 0) begin
                m_busy = 1;
                begin_sweep(ch_mask_i);
            end
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) nstart = 1;
        end else if (m_start) begin
            m_conv = 1;
        end else if (m_conv) begin
            if (conv_rdy_i) begin
                m_conv = 0;
                m_samp.push_back(int'(conv_data_i));
                if (m_samp.size() == NSAMP) begin
                    s = 0;
                    foreach (m_samp[k]) s += m_samp[k];
                    m_data = s / NSAMP;
                    m_valid = 1;
                    m_samp.delete();
                end else begin
                    nstart = 1;
                end
            end
        end else if (m_valid && res_ready_i) begin
            m_valid = 0;
            void'(m_list.pop_front());
            if (m_list.size() == 0) begin
                ndone = 1;
                if (en_i && ch_mask_i != 0) begin_sweep(ch_mask_i);
                else m_busy = 0;
            end else if (en_i) begin
                m_ch = m_list[0];
                m_settle = SETTLE_CYC;
            end else begin
                m_busy = 0;
            end
        end
        m_start = nstart;
        m_done  = ndone;
    endtask

    // Compare, then drive the SAR core stand-in, then advance the model
    // with the inputs the next rising edge will see.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            model_reset();
            core_wait = 0;
        end
        chk("busy", int'(busy_o), int'(m_busy));
        chk("conv_start", int'(conv_start_o), int'(m_start));
        chk("res_valid", int'(res_valid_o), int'(m_valid));
        chk("sweep_done", int'(sweep_done_o), int'(m_done));
        chk("mux_sel", int'(mux_sel_o), m_ch);
        if (!rst_ni || m_valid) begin
            chk("res_ch", int'(res_ch_o), m_ch);
            chk("res_data", int'(res_data_o), m_data);
        end
        conv_rdy_i = 1'b0;
        if (rst_ni) begin
            if (conv_start_o) begin
                core_wait = $urandom_range(1, 4);
            end else if (core_wait > 0) begin
                core_wait--;
                if (core_wait == 0) begin
                    conv_rdy_i = 1'b1;
                    if (core_q.size() > 0) conv_data_i = core_q.pop_front();
                    else conv_data_i = 8'($urandom);
                end
            end
        end
        if (!conv_rdy_i) conv_data_i = 8'($urandom);
        if (rst_ni) model_step();
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid_o) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (conv_start_o) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         first;
        int         bad_v, bad_s, bad_m, cnt;
        logic [7:0] d0;
        logic [CHW-1:0] c0, mx0;

        repeat (3) tick();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_mux", int'(mux_sel_o), 0);
        chk("rst_valid", int'(res_valid_o), 0);
        chk("rst_data", int'(res_data_o), 0);

        // Fixed-data sweep over channels 1 and 3, with start timing.
        rst_ni = 1'b1;
        ch_mask_i = 4'b1010;
        res_ready_i = 1'b1;
        repeat (2 * NSAMP) core_q.push_back(8'h5A);
        tick();
        tick();
        en_i = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (conv_start_o) begin
                first = i;
                break;
            end
        end
        chk("start_delay", first, SETTLE_CYC + 1);
        chk("start_mux", int'(mux_sel_o), 1);
        tick();
        chk("start_one_cycle", int'(conv_start_o), 0);
        wait_valid(80, ok);
        chk("res1_timeout", int'(ok), 1);
        chk("res1_ch", int'(res_ch_o), 1);
        chk("res1_data", int'(res_data_o), 8'h5A);
        tick();
        wait_valid(80, ok);
        chk("res2_timeout", int'(ok), 1);
        chk("res2_ch", int'(res_ch_o), 3);
        chk("res2_data", int'(res_data_o), 8'h5A);
        tick();
        chk("sweep_done_pulse", int'(sweep_done_o), 1);
        chk("restart_mux", int'(mux_sel_o), 1);
        chk("restart_busy", int'(busy_o), 1);

        // Back-pressure: result held, scan stalled.
        res_ready_i = 1'b0;
        wait_valid(80, ok);
        chk("stall_timeout", int'(ok), 1);
        d0 = res_data_o;
        c0 = res_ch_o;
        mx0 = mux_sel_o;
        chk("stall_ch", int'(c0), 1);
        bad_v = 0;
        bad_s = 0;
        bad_m = 0;
        repeat (20) begin
            tick();
            if (!res_valid_o || res_data_o != d0 || res_ch_o != c0) bad_v++;
            if (conv_start_o) bad_s++;
            if (mux_sel_o != mx0) bad_m++;
        end
        chk("stall_result_stable", bad_v, 0);
        chk("stall_no_start", bad_s, 0);
        chk("stall_mux_stable", bad_m, 0);
        res_ready_i = 1'b1;

        // Enable dropped during conversion on channel 0.
        en_i = 1'b0;
        wait_idle(200, ok);
        chk("idle1_timeout", int'(ok), 1);
        ch_mask_i = 4'b0011;
        en_i = 1'b1;
        wait_start(40, ok);
        chk("c_start_timeout", int'(ok), 1);
        tick();
        en_i = 1'b0;
        wait_valid(80, ok);
        chk("c_res_timeout", int'(ok), 1);
        chk("c_res_ch", int'(res_ch_o), 0);
        tick();
        chk("c_idle", int'(busy_o), 0);
        chk("c_no_done", int'(sweep_done_o), 0);
        cnt = 0;
        repeat (30) begin
            tick();
            if (conv_start_o || sweep_done_o || busy_o) cnt++;
        end
        chk("c_stays_idle", cnt, 0);

        // Reset asserted mid-conversion.
        ch_mask_i = 4'b0110;
        en_i = 1'b1;
        wait_start(40, ok);
        chk("d_start_timeout", int'(ok), 1);
        tick();
        #1 rst_ni = 1'b0;
        #1;
        chk("d_busy", int'(busy_o), 0);
        chk("d_start", int'(conv_start_o), 0);
        chk("d_valid", int'(res_valid_o), 0);
        chk("d_mux", int'(mux_sel_o), 0);
        chk("d_res_ch", int'(res_ch_o), 0);
        chk("d_res_data", int'(res_data_o), 0);
        chk("d_done", int'(sweep_done_o), 0);
        tick();
        tick();
        rst_ni = 1'b1;
        wait_start(40, ok);
        chk("d_restart_timeout", int'(ok), 1);
        chk("d_restart_mux", int'(mux_sel_o), 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            res_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) ch_mask_i = NUM_CH'($urandom);
            if ($urandom_range(0, 99) == 0) en_i = ~en_i;
        end

`ifdef SAR_SCAN_AVG_EN
        // Averaging: samples 10, 11, 12, 14 -> 11.
        en_i = 1'b0;
        res_ready_i = 1'b1;
        wait_idle(400, ok);
        chk("avg_idle_timeout", int'(ok), 1);
        core_q.push_back(8'd10);
        core_q.push_back(8'd11);
        core_q.push_back(8'd12);
        core_q.push_back(8'd14);
        ch_mask_i = 4'b0001;
        en_i = 1'b1;
        cnt = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (conv_start_o) cnt++;
            if (res_valid_o) begin
                ok = 1;
                break;
            end
        end
        chk("avg_timeout", int'(ok), 1);
        chk("avg_starts", cnt, 4);
        chk("avg_data", int'(res_data_o), 11);
        chk("avg_ch", int'(res_ch_o), 0);
`endif

        en_i = 1'b0;
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
